// File: rtl/adxl362_pkg.sv
// rtl/adxl362_pkg.sv - shared constants, FSM encoding and frame builder for the ADXL362 SPI master
package adxl362_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h0A;
  localparam logic [7:0] CMD_READ  = 8'h0B;
  localparam logic [7:0] CMD_FIFO  = 8'h0D;  // reserved, not issued by this master

  localparam int FRAME_BITS = 24;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_SHIFT,
    ST_HOLD,
    ST_GAP
  } spi_state_t;

  // Command byte, address byte, data byte; reads send a zero data byte.
  function automatic logic [FRAME_BITS-1:0] build_frame(input logic       wr,
                                                         input logic [5:0] addr,
                                                         input logic [7:0] wdata);
    return {(wr ? CMD_WRITE : CMD_READ), 2'b00, addr, (wr ? wdata : 8'h00)};
  endfunction

endpackage

// File: rtl/adxl362_spi_master_if.sv
// rtl/adxl362_spi_master_if.sv - fabric-side request/response bundle of the ADXL362 SPI master
interface adxl362_spi_master_if;

  logic       start;
  logic       write;
  logic [5:0] address;
  logic [7:0] data_write;
  logic [7:0] data_read;
  logic       busy;
  logic       done;

  // Requester (fabric) side
  modport master (
    output start, write, address, data_write,
    input  data_read, busy, done
  );

  // SPI master block side
  modport slave (
    input  start, write, address, data_write,
    output data_read, busy, done
  );

endinterface

// File: rtl/adxl362_spi_shifter.sv
// rtl/adxl362_spi_shifter.sv - 24-bit MOSI shift register plus MISO capture byte
module adxl362_spi_shifter
  import adxl362_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  load,
  input  logic [FRAME_BITS-1:0] load_data,
  input  logic                  shift_out,
  input  logic                  shift_in,
  input  logic                  miso,
  output logic                  mosi,
  output logic [7:0]            rx_byte
);

  logic [FRAME_BITS-1:0] tx_q;
  logic [7:0]            rx_q;

  // Outgoing frame: MSB is always on MOSI, shifted left on each SCLK fall.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tx_q <= '0;
    end else if (load) begin
      tx_q <= load_data;
    end else if (shift_out) begin
      tx_q <= {tx_q[FRAME_BITS-2:0], 1'b0};
    end
  end

  // Incoming bits; only the last byte of the frame carries register data.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_q <= '0;
    end else if (load) begin
      rx_q <= '0;
    end else if (shift_in) begin
      rx_q <= {rx_q[6:0], miso};
    end
  end

  assign mosi    = tx_q[FRAME_BITS-1];
  assign rx_byte = rx_q;

endmodule

// File: rtl/adxl362_spi_master.sv
// rtl/adxl362_spi_master.sv - single-register read/write SPI master for the ADXL362 (mode 0)
module adxl362_spi_master
  import adxl362_pkg::*;
#(
  parameter int CLK_DIV = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  adxl362_spi_master_if.slave  bus,
  output logic                 SCLK,
  output logic                 MOSI,
  input  logic                 MISO,
  output logic                 nCS
);

  localparam int              DIV_W    = $clog2(CLK_DIV) + 1;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(CLK_DIV - 1);
  localparam logic [4:0]      BIT_TOP  = 5'(FRAME_BITS - 1);

  spi_state_t       state_q, state_n;
  logic [DIV_W-1:0] div_q, div_n;
  logic [4:0]       bit_q, bit_n;
  logic             sclk_q, sclk_n;
  logic             ncs_q, ncs_n;
  logic             busy_q, busy_n;
  logic             done_q, done_n;
  logic             wr_q, wr_n;
  logic [7:0]       rd_q, rd_n;

  logic             load, shift_out, shift_in;
  logic             div_end;
  logic [7:0]       rx_byte;

  adxl362_spi_shifter u_shifter (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .load_data (build_frame(bus.write, bus.address, bus.data_write)),
    .shift_out (shift_out),
    .shift_in  (shift_in),
    .miso      (MISO),
    .mosi      (MOSI),
    .rx_byte   (rx_byte)
  );

  assign div_end = (div_q == DIV_LAST);

  // State and registered pin/handshake outputs; reset returns the link to idle at once.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      div_q   <= '0;
      bit_q   <= '0;
      sclk_q  <= 1'b0;
      ncs_q   <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      wr_q    <= 1'b0;
      rd_q    <= 8'h00;
    end else begin
      state_q <= state_n;
      div_q   <= div_n;
      bit_q   <= bit_n;
      sclk_q  <= sclk_n;
      ncs_q   <= ncs_n;
      busy_q  <= busy_n;
      done_q  <= done_n;
      wr_q    <= wr_n;
      rd_q    <= rd_n;
    end
  end

  // Next-state and output decode; every phase lasts CLK_DIV clk cycles.
  always_comb begin
    state_n   = state_q;
    div_n     = div_q;
    bit_n     = bit_q;
    sclk_n    = sclk_q;
    ncs_n     = ncs_q;
    busy_n    = busy_q;
    done_n    = 1'b0;
    wr_n      = wr_q;
    rd_n      = rd_q;
    load      = 1'b0;
    shift_out = 1'b0;
    shift_in  = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        div_n = '0;
        // The done cycle still counts as busy for request acceptance.
        if (bus.start && !done_q) begin
          state_n = ST_SETUP;
          load    = 1'b1;
          ncs_n   = 1'b0;
          busy_n  = 1'b1;
          bit_n   = BIT_TOP;
          wr_n    = bus.write;
        end
      end

      ST_SETUP: begin
        if (div_end) begin
          div_n    = '0;
          state_n  = ST_SHIFT;
          sclk_n   = 1'b1;
          shift_in = 1'b1;
        end else begin
          div_n = div_q + DIV_W'(1);
        end
      end

      ST_SHIFT: begin
        if (!div_end) begin
          div_n = div_q + DIV_W'(1);
        end else begin
          div_n = '0;
          if (sclk_q) begin
            // Falling edge: present the next bit unless the last one is out.
            sclk_n    = 1'b0;
            shift_out = (bit_q != 5'd0);
          end else if (bit_q == 5'd0) begin
            state_n = ST_HOLD;
          end else begin
            // Rising edge of the next bit: the slave's MISO bit is sampled here.
            bit_n    = bit_q - 5'd1;
            sclk_n   = 1'b1;
            shift_in = 1'b1;
          end
        end
      end

      ST_HOLD: begin
        if (div_end) begin
          div_n   = '0;
          ncs_n   = 1'b1;
          state_n = ST_GAP;
        end else begin
          div_n = div_q + DIV_W'(1);
        end
      end

      ST_GAP: begin
        if (div_end) begin
          div_n   = '0;
          state_n = ST_IDLE;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          if (!wr_q) begin
            rd_n = rx_byte;
          end
        end else begin
          div_n = div_q + DIV_W'(1);
        end
      end

      default: begin
        state_n = ST_IDLE;
      end
    endcase
  end

  assign SCLK          = sclk_q;
  assign nCS           = ncs_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.data_read = rd_q;

endmodule
